// File: rtl/mprj_io_buffer_pkg.sv
// Shared constants for the management GPIO buffer: default widths, reset levels,
// legal parameter ranges and the debounce counter width.
package mprj_io_buffer_pkg;

  localparam int IN_WIDTH_DEF  = 18;
  localparam int OUT_WIDTH_DEF = 18;
  localparam int OEB_WIDTH_DEF = 3;

  // Output enables are active-low, so every oeb flop resets to 1 (pads tri-stated).
  localparam logic OEB_RST_BIT = 1'b1;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int OUT_STAGES_MIN  = 1;
  localparam int OUT_STAGES_MAX  = 3;
  localparam int DEB_CYCLES_MIN  = 2;
  localparam int DEB_CYCLES_MAX  = 15;

  localparam int DEB_CNT_W = 4;

  function automatic bit in_range(input int val, input int lo, input int hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/mprj_io_in_chan.sv
// One pad input channel: synchroniser, optional debounce (MPRJ_IO_DEBOUNCE_EN), hold register, sticky change flag.
// Latency: SYNC_STAGES+1 clocks, or SYNC_STAGES+DEB_CYCLES+1 with debounce.
// Backpressure: none; freeze holds in_buf while the synchroniser keeps running.
module mprj_io_in_chan #(
  parameter int SYNC_STAGES = 2
`ifdef MPRJ_IO_DEBOUNCE_EN
  , parameter int DEB_CYCLES = 4
`endif
) (
  input  logic clock,
  input  logic resetn,
  input  logic pin,
  input  logic freeze,
  input  logic chg_clr,
  output logic in_buf,
  output logic in_change
);
  import mprj_io_buffer_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic                   load;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef MPRJ_IO_DEBOUNCE_EN
  localparam logic [DEB_CNT_W-1:0] DEB_LIM = DEB_CNT_W'(DEB_CYCLES);

  logic [DEB_CNT_W-1:0] deb_cnt;
  logic                 deb_done;

  assign deb_done = (deb_cnt == DEB_LIM);

  // Counter parks at DEB_LIM while frozen so the qualified edge lands on release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      deb_cnt <= '0;
    end else if (sync_bit == in_buf) begin
      deb_cnt <= '0;
    end else if (deb_done) begin
      if (!freeze) begin
        deb_cnt <= '0;
      end
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign load = !freeze && deb_done && (sync_bit != in_buf);
`else
  assign load = !freeze;
`endif

  // A new set wins over a coincident clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_buf    <= 1'b0;
      in_change <= 1'b0;
    end else begin
      if (load) begin
        in_buf <= sync_bit;
      end
      in_change <= (load && (sync_bit != in_buf)) || (in_change && !chg_clr);
    end
  end

endmodule

// File: rtl/mprj_io_buffer_reg.sv
// Registered management GPIO buffer; optional MPRJ_IO_DEBOUNCE_EN input debounce, USE_POWER_PINS adds VDD/VSS.
// Latency: inputs SYNC_STAGES+1 (+DEB_CYCLES with debounce), out/oeb OUT_STAGES clocks.
// Backpressure: none; freeze holds in_buf and the final out/oeb stage.
module mprj_io_buffer_reg
  import mprj_io_buffer_pkg::*;
#(
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int OEB_WIDTH   = OEB_WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int OUT_STAGES  = 1,
  parameter int DEB_CYCLES  = 4
) (
`ifdef USE_POWER_PINS
  inout  wire                  VDD,
  inout  wire                  VSS,
`endif
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [IN_WIDTH-1:0]  mgmt_gpio_in,
  output logic [IN_WIDTH-1:0]  mgmt_gpio_in_buf,
  input  logic [OUT_WIDTH-1:0] mgmt_gpio_out,
  output logic [OUT_WIDTH-1:0] mgmt_gpio_out_buf,
  input  logic [OEB_WIDTH-1:0] mgmt_gpio_oeb,
  output logic [OEB_WIDTH-1:0] mgmt_gpio_oeb_buf,
  input  logic                 freeze,
  output logic [IN_WIDTH-1:0]  in_change,
  input  logic [IN_WIDTH-1:0]  in_change_clr
);

  if (!in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX)) begin : g_bad_sync
    $error("mprj_io_buffer_reg: SYNC_STAGES must be 2..4");
  end
  if (!in_range(OUT_STAGES, OUT_STAGES_MIN, OUT_STAGES_MAX)) begin : g_bad_out
    $error("mprj_io_buffer_reg: OUT_STAGES must be 1..3");
  end
  if (!in_range(DEB_CYCLES, DEB_CYCLES_MIN, DEB_CYCLES_MAX)) begin : g_bad_deb
    $error("mprj_io_buffer_reg: DEB_CYCLES must be 2..15");
  end
  if (DEB_CYCLES_MAX >= (1 << DEB_CNT_W)) begin : g_bad_cnt_w
    $error("mprj_io_buffer_reg: debounce counter too narrow for DEB_CYCLES_MAX");
  end
  if (IN_WIDTH < 1 || OUT_WIDTH < 1 || OEB_WIDTH < 1) begin : g_bad_width
    $error("mprj_io_buffer_reg: widths must be at least 1");
  end

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_in
    mprj_io_in_chan #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef MPRJ_IO_DEBOUNCE_EN
      , .DEB_CYCLES (DEB_CYCLES)
`endif
    ) u_chan (
      .clock     (clock),
      .resetn    (resetn),
      .pin       (mgmt_gpio_in[i]),
      .freeze    (freeze),
      .chg_clr   (in_change_clr[i]),
      .in_buf    (mgmt_gpio_in_buf[i]),
      .in_change (in_change[i])
    );
  end

  // Data and enable travel as one word so they can never slip relative to each other.
  typedef struct packed {
    logic [OUT_WIDTH-1:0] dat;
    logic [OEB_WIDTH-1:0] oeb;
  } drv_t;

  localparam drv_t DRV_RST = '{dat: '0, oeb: {OEB_WIDTH{OEB_RST_BIT}}};

  drv_t [OUT_STAGES-1:0] pipe_q;
  drv_t [OUT_STAGES-1:0] pipe_d;

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = '{dat: mgmt_gpio_out, oeb: mgmt_gpio_oeb};
    for (int k = 1; k < OUT_STAGES; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  // Upstream stages keep shifting under freeze, so release picks up the newest data directly.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pipe_q <= {OUT_STAGES{DRV_RST}};
    end else begin
      for (int k = 0; k < OUT_STAGES - 1; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
      if (!freeze) begin
        pipe_q[OUT_STAGES-1] <= pipe_d[OUT_STAGES-1];
      end
    end
  end

  assign mgmt_gpio_out_buf = pipe_q[OUT_STAGES-1].dat;
  assign mgmt_gpio_oeb_buf = pipe_q[OUT_STAGES-1].oeb;

endmodule

// File: tb/tb_mprj_io_buffer_reg.sv
// Bench for mprj_io_buffer_reg: two instances (OUT_STAGES=1 and 3) against a history-based reference model.
`timescale 1ns/1ps
module tb_mprj_io_buffer_reg;
  localparam int IW  = 18;
  localparam int OW  = 18;
  localparam int EW  = 3;
  localparam int S   = 2;
  localparam int HD  = 4096;
`ifdef MPRJ_IO_DEBOUNCE_EN
  localparam int DEB = 4;
`endif

  logic          clock  = 1'b0;
  logic          resetn = 1'b0;
  logic          freeze = 1'b0;
  logic [IW-1:0] gin    = '0;
  logic [IW-1:0] clr    = '0;
  logic [OW-1:0] gout   = '0;
  logic [EW-1:0] goeb   = '1;

  logic [IW-1:0] inb1, chg1, inb3, chg3;
  logic [OW-1:0] ob1, ob3;
  logic [EW-1:0] eb1, eb3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mprj_io_buffer_reg dut1 (
    .clock(clock), .resetn(resetn),
    .mgmt_gpio_in(gin), .mgmt_gpio_in_buf(inb1),
    .mgmt_gpio_out(gout), .mgmt_gpio_out_buf(ob1),
    .mgmt_gpio_oeb(goeb), .mgmt_gpio_oeb_buf(eb1),
    .freeze(freeze), .in_change(chg1), .in_change_clr(clr)
  );

  mprj_io_buffer_reg #(.OUT_STAGES(3)) dut3 (
    .clock(clock), .resetn(resetn),
    .mgmt_gpio_in(gin), .mgmt_gpio_in_buf(inb3),
    .mgmt_gpio_out(gout), .mgmt_gpio_out_buf(ob3),
    .mgmt_gpio_oeb(goeb), .mgmt_gpio_oeb_buf(eb3),
    .freeze(freeze), .in_change(chg3), .in_change_clr(clr)
  );

  typedef struct {
    logic [IW-1:0] inb;
    logic [IW-1:0] chg;
    logic [OW-1:0] o1;
    logic [OW-1:0] o3;
    logic [EW-1:0] e1;
    logic [EW-1:0] e3;
  } exp_t;

  exp_t expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: every output is a function of input history since the last reset.
  logic [IW-1:0] pin_h [HD];
  logic [OW-1:0] out_h [HD];
  logic [EW-1:0] oeb_h [HD];
  int            ecnt     = 0;
  int            rst_edge = 0;
  logic [IW-1:0] m_in, m_chg;
  logic [OW-1:0] m_o1, m_o3;
  logic [EW-1:0] m_e1, m_e3;
`ifdef MPRJ_IO_DEBOUNCE_EN
  int            run [IW];
`endif

  function automatic logic [IW-1:0] pin_at(input int k);
    return (k <= rst_edge) ? '0 : pin_h[k % HD];
  endfunction
  function automatic logic [OW-1:0] out_at(input int k);
    return (k <= rst_edge) ? '0 : out_h[k % HD];
  endfunction
  function automatic logic [EW-1:0] oeb_at(input int k);
    return (k <= rst_edge) ? '1 : oeb_h[k % HD];
  endfunction

  always @(posedge clock) begin
    exp_t          x;
    logic [IW-1:0] nin, sv;
    ecnt = ecnt + 1;
    pin_h[ecnt % HD] = gin;
    out_h[ecnt % HD] = gout;
    oeb_h[ecnt % HD] = goeb;
    if (!resetn) begin
      rst_edge = ecnt;
      m_in = '0; m_chg = '0;
      m_o1 = '0; m_o3 = '0; m_e1 = '1; m_e3 = '1;
`ifdef MPRJ_IO_DEBOUNCE_EN
      for (int i = 0; i < IW; i++) run[i] = 0;
`endif
    end else begin
      sv  = pin_at(ecnt - S);
      nin = m_in;
`ifdef MPRJ_IO_DEBOUNCE_EN
      for (int i = 0; i < IW; i++) begin
        if (sv[i] == m_in[i]) run[i] = 0;
        else if (run[i] >= DEB) begin
          if (!freeze) begin nin[i] = sv[i]; run[i] = 0; end
        end else run[i] = run[i] + 1;
      end
`else
      if (!freeze) nin = sv;
`endif
      m_chg = (nin ^ m_in) | (m_chg & ~clr);
      m_in  = nin;
      if (!freeze) begin
        m_o1 = out_at(ecnt);
        m_e1 = oeb_at(ecnt);
        m_o3 = out_at(ecnt - 2);
        m_e3 = oeb_at(ecnt - 2);
      end
    end
    x.inb = m_in; x.chg = m_chg;
    x.o1 = m_o1; x.o3 = m_o3; x.e1 = m_e1; x.e3 = m_e3;
    expq.push_back(x);
  end

  // Monitor: compares the DUT outputs after every edge against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries, expected 1", $time);
      end else begin
        x = expq.pop_front();
        check("in_buf_s1",  32'(inb1), 32'(x.inb));
        check("in_chg_s1",  32'(chg1), 32'(x.chg));
        check("out_buf_s1", 32'(ob1),  32'(x.o1));
        check("oeb_buf_s1", 32'(eb1),  32'(x.e1));
        check("in_buf_s3",  32'(inb3), 32'(x.inb));
        check("in_chg_s3",  32'(chg3), 32'(x.chg));
        check("out_buf_s3", 32'(ob3),  32'(x.o3));
        check("oeb_buf_s3", 32'(eb3),  32'(x.e3));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    // Reset held with non-reset inputs present.
    gout = 18'h3FFFF; goeb = '0; resetn = 1'b0;
    step(5);
    gout = '0; goeb = '1; resetn = 1'b1;
    step(4);

    // Latency with single edges on in[0] and out.
    gin = 18'h00001; gout = 18'h2A5A5;
    step(6);

    // Freeze across an out/oeb change.
    freeze = 1'b1; gout = 18'h15A5A; goeb = '0;
    step(5);
    freeze = 1'b0;
    step(5);

    // Change-flag priority on bit 3.
    clr = '1; step(1); clr = '0; step(1);
    gin[3] = 1'b1; step(6);
    gin[3] = 1'b0; step(2);
    clr[3] = 1'b1; step(1); clr = '0; step(3);
    clr[3] = 1'b1; step(1); clr = '0; step(3);

    // Short then long pulse on bit 5.
    gin[5] = 1'b1; step(3); gin[5] = 1'b0; step(8);
    gin[5] = 1'b1; step(6); gin[5] = 1'b0; step(10);

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) gin = IW'($urandom);
      gout   = OW'($urandom);
      goeb   = EW'($urandom);
      if ($urandom_range(0, 5) == 0) freeze = ~freeze;
      clr    = ($urandom_range(0, 3) == 0) ? IW'($urandom) : '0;
      step(1);
    end
    freeze = 1'b0; clr = '0;
    step(4);

    // Asynchronous reset mid-run with the 3-stage chain loaded.
    gout = 18'h3C3C3; goeb = 3'b010;
    step(4);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_out_s1", 32'(ob1),  32'h0);
    check("async_rst_out_s3", 32'(ob3),  32'h0);
    check("async_rst_oeb_s1", 32'(eb1),  32'h7);
    check("async_rst_oeb_s3", 32'(eb3),  32'h7);
    check("async_rst_in_s3",  32'(inb3), 32'h0);
    check("async_rst_chg_s3", 32'(chg3), 32'h0);
    step(2);
    gout = 18'h12345; resetn = 1'b1;
    step(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mprj_io_buffer_reg.md
Name: mprj_io_buffer_reg

Overview:
- Registered, parametrised successor to the management GPIO buffer, sitting between the housekeeping/management core and the user-project GPIO control blocks.
- Input path: pad-side inputs are synchronised, then optionally debounced, into the clock domain, with sticky per-bit change flags.
- Output and output-enable path: retimed by a configurable number of stages.
- A freeze input holds every buffered output stable while pad configuration is being reloaded.

Parameters:
IN_WIDTH, 18, number of mgmt_gpio_in channels
OUT_WIDTH, 18, number of mgmt_gpio_out channels
OEB_WIDTH, 3, number of mgmt_gpio_oeb channels
SYNC_STAGES, 2, input synchroniser depth; legal 2..4
OUT_STAGES, 1, out/oeb retiming depth; legal 1..3
DEB_CYCLES, 4, debounce qualification length in cycles; legal 2..15; used only with MPRJ_IO_DEBOUNCE_EN

Ports:
clock  input  1  block clock
resetn  input  1  asynchronous active-low reset
VDD/VSS  inout  1  power pins, present only under USE_POWER_PINS
mgmt_gpio_in  input  IN_WIDTH  asynchronous pad-side inputs
mgmt_gpio_in_buf  output  IN_WIDTH  synchronised inputs
mgmt_gpio_out  input  OUT_WIDTH  output data from management
mgmt_gpio_out_buf  output  OUT_WIDTH  retimed output data
mgmt_gpio_oeb  input  OEB_WIDTH  output enables, active-low
mgmt_gpio_oeb_buf  output  OEB_WIDTH  retimed output enables
freeze  input  1  hold all buffered outputs
in_change  output  IN_WIDTH  sticky per-bit input-change flags
in_change_clr  input  IN_WIDTH  per-bit clear, one-cycle pulse

Behaviour:
- Clock and reset: single clock, asynchronous active-low reset on resetn. Every flop resets asynchronously and releases on the first clock edge after resetn rises.
- Reset values:
  - mgmt_gpio_in_buf = 0; all synchroniser flops = 0.
  - mgmt_gpio_out_buf = 0; all out pipeline stages = 0.
  - mgmt_gpio_oeb_buf = all 1s (pads tri-stated); all oeb pipeline stages = all 1s.
  - in_change = 0; debounce counters = 0.
- Input path:
  - SYNC_STAGES flops, always running, including during freeze, followed by an in_buf hold register.
  - Without debounce: a stable input edge reaches mgmt_gpio_in_buf after SYNC_STAGES+1 clocks.
- Out/oeb path:
  - OUT_STAGES register chain; mgmt_gpio_out_buf and mgmt_gpio_oeb_buf are the final stage.
  - Latency is OUT_STAGES clocks. out and oeb are always aligned to the same cycle.
- Freeze:
  - While freeze=1, in_buf and the final out/oeb stage hold their values.
  - Earlier out/oeb stages keep shifting, so they carry the newest input values.
  - On the first clock with freeze=0, the final stages load from their predecessors; there is no bubble and no replay of stale data.
  - freeze is synchronous to clock and is not internally synchronised.
- Change detect:
  - in_change[i] sets on the clock where in_buf[i] updates to a value different from its current value.
  - It stays set until in_change_clr[i]=1. If set and clear occur in the same cycle, set wins.
  - Because in_buf is held during freeze, no flag sets while freeze=1. A difference accumulated during freeze sets the flag on release.
  - Flags stay 0 in the cycle resetn deasserts.
- Reset mid-operation: asserting resetn low forces the reset values immediately, regardless of clock or freeze.

Optional Feature:
- Macro: MPRJ_IO_DEBOUNCE_EN.
- When defined:
  - Each input bit has a 4-bit counter between the synchroniser and in_buf.
  - The counter increments while the synchronised bit differs from in_buf[i] and resets to 0 when they match.
  - When it reaches DEB_CYCLES, in_buf[i] takes the new value and the counter clears.
  - A glitch shorter than DEB_CYCLES synchronised cycles is never propagated.
  - Latency is SYNC_STAGES+DEB_CYCLES+1 clocks.
  - During freeze the counter saturates at DEB_CYCLES and does not update in_buf.
- When not defined: no counters are generated, and in_buf loads the synchroniser output every unfrozen cycle.

Decomposition:
- Package mprj_io_buffer_pkg holds:
  - default widths (18/18/3);
  - OEB reset constant (all 1s);
  - legal ranges for SYNC_STAGES, OUT_STAGES and DEB_CYCLES;
  - the debounce counter width (4).
- Elaboration-time checks reject illegal parameter values.
- One sub-module, mprj_io_in_chan: a per-bit synchroniser, optional debounce, hold register and change flag, instantiated IN_WIDTH times.
- The out/oeb retiming chain stays inline in mprj_io_buffer_reg.

Test Plan:
1. Reset:
   - Stimulus: hold resetn=0 with mgmt_gpio_out=3FFFF and mgmt_gpio_oeb=0.
   - Required: out_buf=0, oeb_buf=7, in_buf=0 and in_change=0, all held throughout reset.
2. Latency, default parameters:
   - Stimulus: mgmt_gpio_in 0 -> 00001; mgmt_gpio_out 0 -> 2A5A5.
   - Required: in_buf=00001 exactly 3 clocks later, with in_change[0]=1 on the same clock; out_buf=2A5A5 exactly 1 clock later.
3. Freeze:
   - Stimulus: freeze=1; change out to 15A5A and oeb to 0; wait 5 clocks; set freeze=0.
   - Required: out_buf/oeb_buf stay at their old values during freeze; they equal 15A5A/0 on the first clock after release; no intermediate value appears.
4. Change-flag priority:
   - Stimulus: in_change_clr[3] pulse coinciding with an in_buf[3] toggle.
   - Required: flag remains 1; a later isolated clr pulse clears it to 0.
5. Debounce (build with MPRJ_IO_DEBOUNCE_EN, DEB_CYCLES=4):
   - Stimulus: a 3-cycle pulse on bit 5, then a 6-cycle pulse.
   - Required: the first pulse is ignored and in_change[5]=0; the second pulse sets in_buf[5] SYNC_STAGES+5 clocks after its onset and sets in_change[5].
6. Mid-run reset:
   - Stimulus: drop resetn asynchronously between clock edges while OUT_STAGES=3 is fully loaded.
   - Required: outputs reach reset values before the next edge; after release, out_buf equals the current input 3 clocks later.
